// File: rtl/regfile_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_arb_pkg
//   Shared types and constants for the register-file write arbiter.
//   - arb_state_t : arbiter FSM state (NORMAL, FORCE_B)
//   - REG_ADDR_W  : register address width
//   - DATA_W      : register data width
//   - REG_ZERO    : hard-wired zero register; writes to it are suppressed
//   - CNT_W       : width of the starvation counter (covers limits 1..15)
//   - read_hazard : true when a read address hits the pending write
// ---------------------------------------------------------------------------
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 4;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        NORMAL  = 1'b0,
        FORCE_B = 1'b1
    } arb_state_t;

    // A read is stale while the registered write is still waiting to commit.
    // The zero register never holds written data, so it can never be stale.
    function automatic logic read_hazard(
        input logic                  wr_en,
        input logic [REG_ADDR_W-1:0] rd_reg,
        input logic [REG_ADDR_W-1:0] wr_reg
    );
        return wr_en && (rd_reg == wr_reg) && (wr_reg != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bundles the two write requesters, the register-file write port and the
//   read-address snoop / hazard flags.
//
//   Handshake: a request transfers only on a cycle where Valid and Ready are
//   both 1; the requester keeps Valid, Reg and Data stable until that cycle.
//   Ready is combinational and may depend on the other requester's Valid.
//
//   Modports:
//   - slave  : arbiter view (requests and read addresses in, readies,
//              write port and hazards out)
//   - master : environment view (the opposite directions)
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if;
    import regfile_arb_pkg::*;

    // Requester A: pipeline writeback
    logic                  A_Valid;
    logic [REG_ADDR_W-1:0] A_Reg;
    logic [DATA_W-1:0]     A_Data;
    logic                  A_Ready;

    // Requester B: multicycle SAD unit
    logic                  B_Valid;
    logic [REG_ADDR_W-1:0] B_Reg;
    logic [DATA_W-1:0]     B_Data;
    logic                  B_Ready;

    // Write port to RegisterFile
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0]     WriteData;

    // Read-address snoop and stale-read flags
    logic [REG_ADDR_W-1:0] ReadRegister1;
    logic [REG_ADDR_W-1:0] ReadRegister2;
    logic                  Hazard1;
    logic                  Hazard2;

    modport slave (
        input  A_Valid, A_Reg, A_Data,
        input  B_Valid, B_Reg, B_Data,
        input  ReadRegister1, ReadRegister2,
        output A_Ready, B_Ready,
        output RegWrite, WriteRegister, WriteData,
        output Hazard1, Hazard2
    );

    modport master (
        output A_Valid, A_Reg, A_Data,
        output B_Valid, B_Reg, B_Data,
        output ReadRegister1, ReadRegister2,
        input  A_Ready, B_Ready,
        input  RegWrite, WriteRegister, WriteData,
        input  Hazard1, Hazard2
    );

endinterface

// File: rtl/regfile_write_arbiter_starve_counter.sv
// ---------------------------------------------------------------------------
// starve_counter
//   Counts consecutive cycles in which requester B was refused.
//
//   Ports:
//   - Clk, Reset_n : clock, asynchronous active-low reset
//   - inc          : B was refused this cycle
//   - clr          : B transferred, or gave up while being forced
//   - at_limit     : this increment makes the count reach LIMIT
//   - count        : current count (debug visibility)
// ---------------------------------------------------------------------------
module starve_counter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic             at_limit,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Flag on the increment itself so the FSM switches on the same edge at
    // which the count lands on LIMIT.
    assign at_limit = inc && (cnt_q == LIMIT_M1);
    assign count    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//   Arbitrates two write requesters onto the single register-file write
//   port. A (pipeline writeback) has fixed priority; B (SAD unit) is forced
//   through after STARVE_LIMIT consecutive refusals. The accepted request is
//   registered (one cycle latency) and read addresses are snooped to flag
//   reads that would return a stale value while that write is pending.
//
//   Ports:
//   - Clk, Reset_n     : clock, asynchronous active-low reset
//   - bus              : requesters, write port, read snoop, hazard flags
//   - dbg_state_o      : current FSM state
//   - dbg_starve_cnt_o : current starvation count
// ---------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    regfile_write_arbiter_if.slave       bus,
    output arb_state_t                   dbg_state_o,
    output logic [CNT_W-1:0]             dbg_starve_cnt_o
);

    arb_state_t            state_q, state_d;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;

    logic a_ready, b_ready;
    logic a_xfer, b_xfer;
    logic starve_inc, starve_clr, starve_at_limit;

    // Readies depend only on state and the other side's Valid. Reset drives
    // the state to NORMAL asynchronously, so readies follow NORMAL during
    // reset while the registers ignore every edge.
    assign a_ready = (state_q == NORMAL);
    assign b_ready = (state_q == NORMAL) ? !bus.A_Valid : 1'b1;

    assign a_xfer = bus.A_Valid && a_ready;
    assign b_xfer = bus.B_Valid && b_ready;

    assign starve_inc = (state_q == NORMAL) && bus.B_Valid && !b_ready;
    assign starve_clr = b_xfer || ((state_q == FORCE_B) && !bus.B_Valid);

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .at_limit (starve_at_limit),
        .count    (dbg_starve_cnt_o)
    );

    // Next state and next write-port contents. The readies make a_xfer and
    // b_xfer mutually exclusive, so the order of the if/else is only for
    // clarity.
    always_comb begin
        state_d     = state_q;
        reg_write_d = 1'b0;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;

        unique case (state_q)
            NORMAL: begin
                if (starve_at_limit) begin
                    state_d = FORCE_B;
                end
            end
            FORCE_B: begin
                // Leave once B has gone through or has withdrawn.
                if (b_xfer || !bus.B_Valid) begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase

        // Zero-register requests still complete the handshake but never
        // assert the write enable.
        if (a_xfer) begin
            reg_write_d = (bus.A_Reg != REG_ZERO);
            wr_reg_d    = bus.A_Reg;
            wr_data_d   = bus.A_Data;
        end else if (b_xfer) begin
            reg_write_d = (bus.B_Reg != REG_ZERO);
            wr_reg_d    = bus.B_Reg;
            wr_data_d   = bus.B_Data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= NORMAL;
            reg_write_q <= 1'b0;
            wr_reg_q    <= REG_ZERO;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            reg_write_q <= reg_write_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.A_Ready       = a_ready;
    assign bus.B_Ready       = b_ready;
    assign bus.RegWrite      = reg_write_q;
    assign bus.WriteRegister = wr_reg_q;
    assign bus.WriteData     = wr_data_q;

    assign bus.Hazard1 = read_hazard(reg_write_q, bus.ReadRegister1, wr_reg_q);
    assign bus.Hazard2 = read_hazard(reg_write_q, bus.ReadRegister2, wr_reg_q);

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Directed bench for regfile_write_arbiter (STARVE_LIMIT = 4). A small
//   register-file model commits the arbiter's write port so written values
//   can be read back against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Reset_n = 1'b1;

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT ----------------
    regfile_write_arbiter_if bus_if ();
    arb_state_t              dbg_state;
    logic [CNT_W-1:0]        dbg_cnt;

    regfile_write_arbiter #(
        .STARVE_LIMIT (4)
    ) dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .bus              (bus_if),
        .dbg_state_o      (dbg_state),
        .dbg_starve_cnt_o (dbg_cnt)
    );

    // ---------------- register-file model ----------------
    logic [DATA_W-1:0] rf [32] = '{default: 32'h0};

    always @(posedge Clk) begin
        if (bus_if.RegWrite && (bus_if.WriteRegister != REG_ZERO)) begin
            rf[bus_if.WriteRegister] <= bus_if.WriteData;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus_if.A_Valid = v;
        bus_if.A_Reg   = r;
        bus_if.A_Data  = d;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus_if.B_Valid = v;
        bus_if.B_Reg   = r;
        bus_if.B_Data  = d;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        drive_a(1'b0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        bus_if.ReadRegister1 = 5'd0;
        bus_if.ReadRegister2 = 5'd0;

        // Reset: outputs cleared, readies follow NORMAL, no transfer lands.
        #1 Reset_n = 1'b0;
        #2;
        check1 ("rst_regwrite", bus_if.RegWrite, 1'b0);
        check32("rst_wreg",     32'(bus_if.WriteRegister), 32'd0);
        check32("rst_wdata",    bus_if.WriteData, 32'h0);
        check32("rst_state",    32'(dbg_state), 32'(NORMAL));
        check32("rst_cnt",      32'(dbg_cnt), 32'd0);
        drive_a(1'b1, 5'd3, 32'hAA);
        drive_b(1'b1, 5'd4, 32'hBB);
        #1;
        check1("rst_a_ready", bus_if.A_Ready, 1'b1);
        check1("rst_b_ready", bus_if.B_Ready, 1'b0);
        tick();
        check1 ("rst_no_xfer", bus_if.RegWrite, 1'b0);
        check32("rst_no_inc",  32'(dbg_cnt), 32'd0);
        drive_a(1'b0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        Reset_n = 1'b1;
        tick();

        // Solo A: reg 8 <= 5.
        drive_a(1'b1, 5'd8, 32'h5);
        #1 check1("solo_a_ready", bus_if.A_Ready, 1'b1);
        tick();
        drive_a(1'b0, 5'd0, 32'h0);
        #1;
        check1 ("solo_regwrite", bus_if.RegWrite, 1'b1);
        check32("solo_wreg",     32'(bus_if.WriteRegister), 32'd8);
        check32("solo_wdata",    bus_if.WriteData, 32'h5);
        tick();
        check1 ("solo_idle_regwrite", bus_if.RegWrite, 1'b0);
        check32("solo_hold_wreg",     32'(bus_if.WriteRegister), 32'd8);
        check32("solo_hold_wdata",    bus_if.WriteData, 32'h5);
        check32("solo_rf8",           rf[8], 32'h5);

        // Zero register: accepted, but no write enable.
        drive_a(1'b1, 5'd0, 32'hFFFF);
        #1 check1("zero_a_ready", bus_if.A_Ready, 1'b1);
        tick();
        drive_a(1'b0, 5'd0, 32'h0);
        #1 check1("zero_regwrite", bus_if.RegWrite, 1'b0);
        tick();
        check32("zero_rf0", rf[0], 32'h0);

        // Hazard: write reg 25 while reading 25 and 8.
        bus_if.ReadRegister1 = 5'd25;
        bus_if.ReadRegister2 = 5'd8;
        drive_a(1'b1, 5'd25, 32'h0000FFFF);
        tick();
        drive_a(1'b0, 5'd0, 32'h0);
        #1;
        check1("haz_regwrite", bus_if.RegWrite, 1'b1);
        check1("haz_h1",       bus_if.Hazard1, 1'b1);
        check1("haz_h2",       bus_if.Hazard2, 1'b0);
        tick();
        check1 ("haz_h1_idle", bus_if.Hazard1, 1'b0);
        check32("haz_rf25",    rf[25], 32'h0000FFFF);
        bus_if.ReadRegister1 = 5'd0;
        bus_if.ReadRegister2 = 5'd0;

        // Contention: A streams regs 9.., B wants reg 21 <= 0x14.
        drive_a(1'b1, 5'd9, 32'h109);
        drive_b(1'b1, 5'd21, 32'h14);
        for (int c = 0; c < 4; c++) begin
            #1;
            check1 ("cont_a_ready", bus_if.A_Ready, 1'b1);
            check1 ("cont_b_ready", bus_if.B_Ready, 1'b0);
            check32("cont_cnt",     32'(dbg_cnt), 32'(c));
            tick();
            drive_a(1'b1, 5'(10 + c), 32'h100 + 32'(10 + c));
        end
        #1;
        check32("cont_force_state", 32'(dbg_state), 32'(FORCE_B));
        check32("cont_force_cnt",   32'(dbg_cnt), 32'd4);
        check1 ("cont_a_stall",     bus_if.A_Ready, 1'b0);
        check1 ("cont_b_grant",     bus_if.B_Ready, 1'b1);
        check32("cont_wreg12",      32'(bus_if.WriteRegister), 32'd12);
        tick();
        drive_b(1'b0, 5'd0, 32'h0);
        #1;
        check32("cont_back_state", 32'(dbg_state), 32'(NORMAL));
        check32("cont_back_cnt",   32'(dbg_cnt), 32'd0);
        check1 ("cont_a_resume",   bus_if.A_Ready, 1'b1);
        check1 ("cont_b_regwrite", bus_if.RegWrite, 1'b1);
        check32("cont_b_wreg",     32'(bus_if.WriteRegister), 32'd21);
        check32("cont_b_wdata",    bus_if.WriteData, 32'h14);
        tick();
        drive_a(1'b0, 5'd0, 32'h0);
        #1 check32("cont_a13_wreg", 32'(bus_if.WriteRegister), 32'd13);
        tick();
        check32("cont_rf21", rf[21], 32'h14);
        check32("cont_rf12", rf[12], 32'h10C);
        check32("cont_rf13", rf[13], 32'h10D);

        // B withdraws while forced: back to NORMAL, counter cleared.
        drive_a(1'b1, 5'd1, 32'h11);
        drive_b(1'b1, 5'd22, 32'h22);
        repeat (4) tick();
        drive_b(1'b0, 5'd0, 32'h0);
        #1;
        check32("drop_state_force", 32'(dbg_state), 32'(FORCE_B));
        check1 ("drop_a_stall",     bus_if.A_Ready, 1'b0);
        tick();
        check32("drop_state_normal", 32'(dbg_state), 32'(NORMAL));
        check32("drop_cnt",          32'(dbg_cnt), 32'd0);
        check1 ("drop_no_write",     bus_if.RegWrite, 1'b0);
        tick();
        drive_a(1'b0, 5'd0, 32'h0);
        tick();
        check32("drop_rf22", rf[22], 32'h0);
        check32("drop_rf1",  rf[1], 32'h11);

        // Reset mid-operation while forced with B pending.
        drive_b(1'b1, 5'd30, 32'hDEAD);
        for (int c = 0; c < 4; c++) begin
            drive_a(1'b1, 5'(2 + c), 32'h200 + 32'(2 + c));
            tick();
        end
        check32("mrst_state_force", 32'(dbg_state), 32'(FORCE_B));
        check1 ("mrst_pre_regwrite", bus_if.RegWrite, 1'b1);
        Reset_n = 1'b0;
        drive_a(1'b0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
        #1;
        check1 ("mrst_regwrite", bus_if.RegWrite, 1'b0);
        check32("mrst_state",    32'(dbg_state), 32'(NORMAL));
        check32("mrst_cnt",      32'(dbg_cnt), 32'd0);
        #2 Reset_n = 1'b1;
        tick();
        check1("mrst_after_regwrite", bus_if.RegWrite, 1'b0);
        tick();
        check32("mrst_rf30", rf[30], 32'h0);
        check32("mrst_rf4",  rf[4], 32'h204);
        check32("mrst_rf5",  rf[5], 32'h0);

        // Back-to-back: A writes regs 8..25 on consecutive cycles.
        for (int i = 0; i < 18; i++) begin
            drive_a(1'b1, 5'(8 + i), 32'hC000 + 32'(8 + i));
            #1;
            check1("b2b_a_ready", bus_if.A_Ready, 1'b1);
            if (i > 0) begin
                check1 ("b2b_regwrite", bus_if.RegWrite, 1'b1);
                check32("b2b_wreg",     32'(bus_if.WriteRegister), 32'(7 + i));
                check32("b2b_wdata",    bus_if.WriteData, 32'hC000 + 32'(7 + i));
            end
            tick();
        end
        drive_a(1'b0, 5'd0, 32'h0);
        #1;
        check1 ("b2b_last_regwrite", bus_if.RegWrite, 1'b1);
        check32("b2b_last_wreg",     32'(bus_if.WriteRegister), 32'd25);
        tick();
        check1("b2b_end_regwrite", bus_if.RegWrite, 1'b0);
        for (int r = 8; r <= 25; r++) begin
            check32("b2b_rf", rf[r], 32'hC000 + 32'(r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
